// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared types and constants for the 3-digit 7-segment scan
//             display: converter state encoding, blank pattern, digit count
//             and the active-low digit-to-segment decode.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam int         N_DIGITS = 3;

  // Active-low segments, bit order g..a. Nibbles above 9 cannot come out of
  // the converter; they decode to all-off so a fault is visible as blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential double-dabble converter. Starts when the input
//             differs from the last committed value, runs 8 add-3/shift
//             iterations, then commits the three BCD digits at once.
//  Ports    : clk   - clock, rising edge
//             rst_n - synchronous active-low reset
//             value - 8-bit binary input
//             bcd   - committed BCD {hundreds, tens, units}
//             busy  - high while a conversion is in flight
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        busy
);

  conv_state_t state;
  logic [7:0]  shreg;
  logic [7:0]  captured;
  logic [7:0]  last_value;
  logic [11:0] scratch;
  logic [2:0]  iter;
  logic [11:0] scratch_adj;

  // Add-3 correction on every nibble that would overflow past 9 once doubled.
  always_comb begin
    scratch_adj = scratch;
    for (int n = 0; n < N_DIGITS; n++) begin
      if (scratch[n*4 +: 4] >= 4'd5)
        scratch_adj[n*4 +: 4] = scratch[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= 8'd0;
      captured   <= 8'd0;
      last_value <= 8'd0;
      scratch    <= 12'd0;
      iter       <= 3'd0;
      bcd        <= 12'd0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value != last_value) begin
            shreg    <= value;
            captured <= value;
            scratch  <= 12'd0;
            iter     <= 3'd0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          {scratch, shreg} <= {scratch_adj[10:0], shreg, 1'b0};
          iter             <= iter + 3'd1;
          if (iter == 3'd7)
            state <= COMMIT;
        end
        COMMIT: begin
          bcd        <= scratch;
          last_value <= captured;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_display
//  Purpose  : Shows an 8-bit value as three decimal digits on a multiplexed
//             common-anode 7-segment display with optional leading-zero
//             blanking. Only the committed BCD is ever displayed.
//  Ports    : clk   - clock, rising edge
//             rst_n - synchronous active-low reset
//             value - binary value to display
//             seg   - active-low segments, seg[0]=a .. seg[6]=g
//             an    - active-low anodes, an[0]=units .. an[2]=hundreds
//             bcd   - committed BCD {hundreds, tens, units}
//             busy  - conversion in flight
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_LZ   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int DIGIT_CYCLES = (CLK_FREQ / REFRESH_HZ > 1) ? (CLK_FREQ / REFRESH_HZ) : 1;
  localparam int CNT_W        = $clog2(DIGIT_CYCLES) + 1;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       scan_idx;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       seg_next;
  logic [2:0]       an_next;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .bcd   (bcd),
    .busy  (busy)
  );

  always_comb begin
    nibble = 4'd0;
    case (scan_idx)
      2'd0:    nibble = bcd[3:0];
      2'd1:    nibble = bcd[7:4];
      2'd2:    nibble = bcd[11:8];
      default: nibble = 4'd0;
    endcase

    // Tens blanks only when hundreds is also zero, so "105" keeps its 0.
    blank = (BLANK_LZ != 0) &&
            (((scan_idx == 2'd2) && (bcd[11:8] == 4'd0)) ||
             ((scan_idx == 2'd1) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)));

    if (blank) begin
      seg_next = SEG_OFF;
      an_next  = 3'b111;
    end else begin
      seg_next = digit_to_seg(nibble);
      an_next  = ~(3'b001 << scan_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
      seg         <= SEG_OFF;
      an          <= 3'b111;
    end else begin
      if (refresh_cnt == CNT_W'(DIGIT_CYCLES - 1)) begin
        refresh_cnt <= '0;
        scan_idx    <= (scan_idx == 2'(N_DIGITS - 1)) ? 2'd0 : scan_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_display
//  Purpose  : Directed self-checking bench. Two instances share stimulus:
//             one with leading-zero blanking, one without.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  value = 8'd0;
  logic [6:0]  seg_b, seg_n;
  logic [2:0]  an_b, an_n;
  logic [11:0] bcd_b, bcd_n;
  logic        busy_b, busy_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(.CLK_FREQ(12), .REFRESH_HZ(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value),
    .seg(seg_b), .an(an_b), .bcd(bcd_b), .busy(busy_b)
  );

  seg7_scan_display #(.CLK_FREQ(12), .REFRESH_HZ(4), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .value(value),
    .seg(seg_n), .an(an_n), .bcd(bcd_n), .busy(busy_n)
  );

  // Expected scan position: which digit slot the outputs show (3 = none yet).
  int mcnt = 0, midx = 0, mshow = 3;
  always @(posedge clk) begin
    if (!rst_n) begin
      mcnt <= 0; midx <= 0; mshow <= 3;
    end else begin
      mshow <= midx;
      if (mcnt == 2) begin
        mcnt <= 0;
        midx <= (midx == 2) ? 0 : midx + 1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Returns {an, seg} expected for the given slot and decimal digits.
  function automatic logic [9:0] exp_scan(input int slot, input int h, input int t,
                                          input int u, input bit blz);
    int d;
    bit blank;
    if (slot == 3) return {3'b111, 7'h7F};
    d = (slot == 0) ? u : (slot == 1) ? t : h;
    blank = blz && ((slot == 2 && h == 0) || (slot == 1 && h == 0 && t == 0));
    if (blank) return {3'b111, 7'h7F};
    case (slot)
      0: return {3'b110, ref_seg(d)};
      1: return {3'b101, ref_seg(d)};
      default: return {3'b011, ref_seg(d)};
    endcase
  endfunction

  // Watch three full dwell rounds of both instances.
  task automatic check_scan(input string tag, input int h, input int t, input int u);
    logic [9:0] eb, en;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      eb = exp_scan(mshow, h, t, u, 1'b1);
      en = exp_scan(mshow, h, t, u, 1'b0);
      check({tag, " an(blank)"},   {29'd0, an_b},  {29'd0, eb[9:7]});
      check({tag, " seg(blank)"},  {25'd0, seg_b}, {25'd0, eb[6:0]});
      check({tag, " an(noblank)"}, {29'd0, an_n},  {29'd0, en[9:7]});
      check({tag, " seg(noblank)"},{25'd0, seg_n}, {25'd0, en[6:0]});
    end
  endtask

  // Apply a new value and follow it through the whole conversion:
  // busy during the first 9 samples, result committed on the 10th.
  task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] exp_bcd);
    value = v;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check({tag, " busy"}, {31'd0, busy_b}, 32'd1);
    end
    @(negedge clk);
    check({tag, " busy done"}, {31'd0, busy_b}, 32'd0);
    check({tag, " bcd"},       {20'd0, bcd_b},  {20'd0, exp_bcd});
    check({tag, " bcd(nb)"},   {20'd0, bcd_n},  {20'd0, exp_bcd});
  endtask

  initial begin
    // 1. Reset
    rst_n = 1'b0;
    value = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst seg",  {25'd0, seg_b},  32'h7F);
    check("rst an",   {29'd0, an_b},   32'h7);
    check("rst bcd",  {20'd0, bcd_b},  32'h0);
    check("rst busy", {31'd0, busy_b}, 32'h0);
    check("rst seg nb", {25'd0, seg_n}, 32'h7F);
    rst_n = 1'b1;
    check_scan("zero", 0, 0, 0);

    // 2. Full-scale conversion
    convert("255", 8'd255, 12'h255);
    check_scan("scan255", 2, 5, 5);

    // 3. Blanking against no blanking
    convert("7", 8'd7, 12'h007);
    check_scan("scan7", 0, 0, 7);

    // 4. Input changes mid-conversion; restart after commit
    value = 8'd100;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) value = 8'd42;
      @(negedge clk);
      if (k == 10) begin
        check("mid bcd100", {20'd0, bcd_b}, 32'h100);
        check("mid gap",    {31'd0, busy_b}, 32'd0);
      end else if (k == 20) begin
        check("mid bcd042", {20'd0, bcd_b}, 32'h042);
        check("mid done",   {31'd0, busy_b}, 32'd0);
      end else begin
        check("mid busy",   {31'd0, busy_b}, 32'd1);
      end
    end
    check_scan("scan42", 0, 4, 2);

    // 5. Reset in the middle of a conversion
    value = 8'd200;
    repeat (5) @(negedge clk);
    check("pre-rst busy", {31'd0, busy_b}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst bcd",  {20'd0, bcd_b},  32'h000);
    check("midrst busy", {31'd0, busy_b}, 32'd0);
    check("midrst seg",  {25'd0, seg_b},  32'h7F);
    check("midrst an",   {29'd0, an_b},   32'h7);
    rst_n = 1'b1;
    convert("200", 8'd200, 12'h200);
    check_scan("scan200", 2, 0, 0);

    // 6. Counter boundaries
    convert("9",   8'd9,   12'h009);
    convert("10",  8'd10,  12'h010);
    check_scan("scan10", 0, 1, 0);
    convert("99",  8'd99,  12'h099);
    convert("100", 8'd100, 12'h100);
    check_scan("scan100", 1, 0, 0);
    convert("255b", 8'd255, 12'h255);
    convert("0",   8'd0,   12'h000);
    check_scan("scan0", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
